// File: rtl/student_fir_par.sv
// Signed direct-form FIR spread over NUM_LANES parallel MAC lanes, with valid/ready handshakes,
// a coefficient write port, round-half-up scaling and output saturation.
module student_fir_par #(
   parameter int unsigned NUM_TAPS  = 64,
   parameter int unsigned NUM_LANES = 4,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned COEFF_W   = 16,
   parameter int unsigned ACC_W     = 40,
   parameter int unsigned OUT_W     = 16,
   parameter int unsigned OUT_SHIFT = 15
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        clear_i,
   input  logic                        in_valid_i,
   output logic                        in_ready_o,
   input  logic [DATA_W-1:0]           in_data_i,
   output logic                        out_valid_o,
   input  logic                        out_ready_i,
   output logic [OUT_W-1:0]            out_data_o,
   output logic                        out_sat_o,
   output logic [DATA_W-1:0]           shift_out_o,
   input  logic                        coeff_we_i,
   input  logic [$clog2(NUM_TAPS)-1:0] coeff_addr_i,
   input  logic [COEFF_W-1:0]          coeff_wdata_i,
   output logic                        coeff_err_o
);

   localparam int unsigned DEPTH = NUM_TAPS / NUM_LANES;
   localparam int unsigned AW    = $clog2(NUM_TAPS);
   localparam int unsigned CW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned PW    = DATA_W + COEFF_W;
   localparam int unsigned XW    = ACC_W + 1;

   localparam logic signed [ACC_W:0] OutMax = {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
   localparam logic signed [ACC_W:0] OutMin = {{(ACC_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

   typedef enum logic [2:0] {StIdle, StMac, StReduce, StRound, StOut} state_e;

   state_e                     state_q, state_d;
   logic [CW-1:0]              cnt_q, cnt_d;
   logic signed [DATA_W-1:0]   hist_q [NUM_TAPS];
   logic signed [DATA_W-1:0]   hist_d [NUM_TAPS];
   logic signed [COEFF_W-1:0]  coef_q [NUM_TAPS];
   logic signed [COEFF_W-1:0]  coef_d [NUM_TAPS];
   logic signed [ACC_W-1:0]    acc_q [NUM_LANES];
   logic signed [ACC_W-1:0]    acc_d [NUM_LANES];
   logic signed [ACC_W-1:0]    sum_q, sum_d;
   logic [OUT_W-1:0]           out_data_q, out_data_d;
   logic                       out_sat_q, out_sat_d;
   logic [DATA_W-1:0]          shift_out_q, shift_out_d;
   logic                       coeff_err_q, coeff_err_d;

   logic [AW-1:0]              tap_idx [NUM_LANES];
   logic signed [PW-1:0]       prod [NUM_LANES];
   logic signed [ACC_W:0]      sum_ext, rnd;

   // Lane l works on tap j*NUM_LANES + l, where j is the MAC cycle count.
   always_comb begin
      for (int l = 0; l < NUM_LANES; l++) begin
         tap_idx[l] = AW'(32'(cnt_q) * NUM_LANES + 32'(l));
         prod[l]    = coef_q[tap_idx[l]] * hist_q[tap_idx[l]];
      end
   end

   assign sum_ext = {sum_q[ACC_W-1], sum_q};

   if (OUT_SHIFT > 0) begin : g_round
      localparam logic signed [ACC_W:0] RndBias = XW'(1) << (OUT_SHIFT - 1);
      assign rnd = (sum_ext + RndBias) >>> OUT_SHIFT;
   end else begin : g_no_round
      assign rnd = sum_ext;
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      hist_d      = hist_q;
      coef_d      = coef_q;
      acc_d       = acc_q;
      sum_d       = sum_q;
      out_data_d  = out_data_q;
      out_sat_d   = out_sat_q;
      shift_out_d = shift_out_q;
      coeff_err_d = coeff_err_q;

      // Writes land before a same-cycle sample starts its MAC pass.
      if (coeff_we_i) begin
         if (state_q == StIdle && 32'(coeff_addr_i) < NUM_TAPS) begin
            coef_d[coeff_addr_i] = coeff_wdata_i;
         end else begin
            coeff_err_d = 1'b1;
         end
      end

      unique case (state_q)
         StIdle: begin
            if (in_valid_i) begin
               shift_out_d = hist_q[NUM_TAPS-1];
               for (int k = NUM_TAPS - 1; k > 0; k--) begin
                  hist_d[k] = hist_q[k-1];
               end
               hist_d[0] = in_data_i;
               for (int l = 0; l < NUM_LANES; l++) begin
                  acc_d[l] = '0;
               end
               cnt_d   = '0;
               state_d = StMac;
            end
         end
         StMac: begin
            for (int l = 0; l < NUM_LANES; l++) begin
               acc_d[l] = acc_q[l] + {{(ACC_W - PW){prod[l][PW-1]}}, prod[l]};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(DEPTH - 1)) begin
               state_d = StReduce;
            end
         end
         StReduce: begin
            sum_d = '0;
            for (int l = 0; l < NUM_LANES; l++) begin
               sum_d = sum_d + acc_q[l];
            end
            state_d = StRound;
         end
         StRound: begin
            if (rnd > OutMax) begin
               out_data_d = OUT_W'(OutMax);
               out_sat_d  = 1'b1;
            end else if (rnd < OutMin) begin
               out_data_d = OUT_W'(OutMin);
               out_sat_d  = 1'b1;
            end else begin
               out_data_d = OUT_W'(rnd);
               out_sat_d  = 1'b0;
            end
            state_d = StOut;
         end
         StOut: begin
            if (out_ready_i) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Flush wins over everything, but the coefficient bank survives it.
      if (clear_i) begin
         state_d     = StIdle;
         coef_d      = coef_q;
         coeff_err_d = 1'b0;
         for (int k = 0; k < NUM_TAPS; k++) begin
            hist_d[k] = '0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         sum_q       <= '0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
         shift_out_q <= '0;
         coeff_err_q <= 1'b0;
         for (int k = 0; k < NUM_TAPS; k++) begin
            hist_q[k] <= '0;
            coef_q[k] <= '0;
         end
         for (int l = 0; l < NUM_LANES; l++) begin
            acc_q[l] <= '0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hist_q      <= hist_d;
         coef_q      <= coef_d;
         acc_q       <= acc_d;
         sum_q       <= sum_d;
         out_data_q  <= out_data_d;
         out_sat_q   <= out_sat_d;
         shift_out_q <= shift_out_d;
         coeff_err_q <= coeff_err_d;
      end
   end

   assign in_ready_o  = (state_q == StIdle);
   assign out_valid_o = (state_q == StOut);
   assign out_data_o  = out_data_q;
   assign out_sat_o   = out_sat_q;
   assign shift_out_o = shift_out_q;
   assign coeff_err_o = coeff_err_q;

endmodule

// File: tb/tb_student_fir_par.sv
// Bench for student_fir_par: a default instance and a small 8-tap/2-lane instance, both checked
// against a plain-arithmetic convolution model with rounding and saturation.
module tb_student_fir_par;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   int          sel_g;
   logic        in_valid, out_ready, clear, coeff_we;
   logic [15:0] in_data, coeff_wdata;
   logic [5:0]  coeff_addr;
   logic        a_sel, b_sel;

   logic        a_in_ready, a_out_valid, a_out_sat, a_err;
   logic [15:0] a_out_data, a_shift;
   logic        b_in_ready, b_out_valid, b_out_sat, b_err;
   logic [31:0] b_out_data;
   logic [15:0] b_shift;

   logic        m_valid, m_ready, m_sat, m_err;
   logic [63:0] m_data, m_shift;

   assign a_sel   = (sel_g == 0);
   assign b_sel   = (sel_g == 1);
   assign m_valid = a_sel ? a_out_valid : b_out_valid;
   assign m_ready = a_sel ? a_in_ready : b_in_ready;
   assign m_sat   = a_sel ? a_out_sat : b_out_sat;
   assign m_err   = a_sel ? a_err : b_err;
   assign m_data  = a_sel ? 64'(a_out_data) : 64'(b_out_data);
   assign m_shift = a_sel ? 64'(a_shift) : 64'(b_shift);

   student_fir_par u_a (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .clear_i      (clear & a_sel),
      .in_valid_i   (in_valid & a_sel),
      .in_ready_o   (a_in_ready),
      .in_data_i    (in_data),
      .out_valid_o  (a_out_valid),
      .out_ready_i  (out_ready & a_sel),
      .out_data_o   (a_out_data),
      .out_sat_o    (a_out_sat),
      .shift_out_o  (a_shift),
      .coeff_we_i   (coeff_we & a_sel),
      .coeff_addr_i (coeff_addr),
      .coeff_wdata_i(coeff_wdata),
      .coeff_err_o  (a_err)
   );

   student_fir_par #(
      .NUM_TAPS (8),
      .NUM_LANES(2),
      .DATA_W   (16),
      .COEFF_W  (16),
      .ACC_W    (40),
      .OUT_W    (32),
      .OUT_SHIFT(0)
   ) u_b (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .clear_i      (clear & b_sel),
      .in_valid_i   (in_valid & b_sel),
      .in_ready_o   (b_in_ready),
      .in_data_i    (in_data),
      .out_valid_o  (b_out_valid),
      .out_ready_i  (out_ready & b_sel),
      .out_data_o   (b_out_data),
      .out_sat_o    (b_out_sat),
      .shift_out_o  (b_shift),
      .coeff_we_i   (coeff_we & b_sel),
      .coeff_addr_i (coeff_addr[2:0]),
      .coeff_wdata_i(coeff_wdata),
      .coeff_err_o  (b_err)
   );

   int n_cmp = 0;
   int n_err = 0;

   longint      hist_m [2][64];
   longint      coef_m [2][64];
   logic [63:0] exp_y, exp_sat, exp_shift;

   function automatic int taps_of(int s);   return s ? 8 : 64;  endfunction
   function automatic int depth_of(int s);  return s ? 4 : 16;  endfunction
   function automatic int shift_of(int s);  return s ? 0 : 15;  endfunction
   function automatic int ow_of(int s);     return s ? 32 : 16; endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic select(input int s);
      sel_g = s;
      #1;
   endtask

   task automatic reset_model();
      for (int s = 0; s < 2; s++) begin
         for (int k = 0; k < 64; k++) begin
            hist_m[s][k] = 0;
            coef_m[s][k] = 0;
         end
      end
   endtask

   task automatic flush_model();
      for (int k = 0; k < 64; k++) hist_m[sel_g][k] = 0;
   endtask

   // y[n] = sum h[k]*x[n-k], then round-half-up by the shift and clamp to the output range.
   task automatic model_push(input logic [15:0] x);
      int     t  = taps_of(sel_g);
      int     sh = shift_of(sel_g);
      int     ow = ow_of(sel_g);
      longint s  = 0;
      longint mx, mn;
      exp_shift = 64'(hist_m[sel_g][t-1]) & 64'hFFFF;
      for (int k = t - 1; k > 0; k--) hist_m[sel_g][k] = hist_m[sel_g][k-1];
      hist_m[sel_g][0] = longint'($signed(x));
      for (int k = 0; k < t; k++) s += coef_m[sel_g][k] * hist_m[sel_g][k];
      if (sh > 0) s = (s + (longint'(1) <<< (sh - 1))) >>> sh;
      mx = (longint'(1) <<< (ow - 1)) - 1;
      mn = -(longint'(1) <<< (ow - 1));
      exp_sat = 64'd0;
      if (s > mx) begin
         s = mx;
         exp_sat = 64'd1;
      end else if (s < mn) begin
         s = mn;
         exp_sat = 64'd1;
      end
      exp_y = 64'(s) & ((64'd1 << ow) - 64'd1);
   endtask

   task automatic wcoef(input int addr, input logic [15:0] v);
      coeff_we    = 1'b1;
      coeff_addr  = 6'(addr);
      coeff_wdata = v;
      @(posedge clk); #1;
      coeff_we = 1'b0;
      coef_m[sel_g][addr] = longint'($signed(v));
   endtask

   task automatic accept(input logic [15:0] x);
      in_valid = 1'b1;
      in_data  = x;
      @(posedge clk); #1;
      in_valid = 1'b0;
      model_push(x);
   endtask

   task automatic wait_out(input string tag, input bit chk_lat);
      int cyc = 0;
      while (!m_valid && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, "_valid"}, 64'(m_valid), 64'd1);
      if (chk_lat) check({tag, "_latency"}, 64'(cyc), 64'(depth_of(sel_g) + 2));
      check({tag, "_y"}, m_data, exp_y);
      check({tag, "_sat"}, 64'(m_sat), exp_sat);
      check({tag, "_shift_out"}, m_shift, exp_shift);
   endtask

   task automatic pop();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic send(input logic [15:0] x, input string tag);
      accept(x);
      wait_out(tag, 1'b1);
      pop();
      check({tag, "_back_idle"}, 64'(m_ready), 64'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: observed no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int seen;
      in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0; coeff_we = 1'b0;
      in_data = '0; coeff_wdata = '0; coeff_addr = '0;
      sel_g = 0;
      rst_n = 1'b0;
      reset_model();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      for (int s = 0; s < 2; s++) begin
         select(s);
         check("rst_in_ready", 64'(m_ready), 64'd1);
         check("rst_out_valid", 64'(m_valid), 64'd0);
         check("rst_out_data", m_data, 64'd0);
         check("rst_out_sat", 64'(m_sat), 64'd0);
         check("rst_shift_out", m_shift, 64'd0);
         check("rst_coeff_err", 64'(m_err), 64'd0);
      end

      // Small instance: impulse through h[k]=k+1 reads the coefficients back out in order.
      select(1);
      for (int k = 0; k < 8; k++) wcoef(k, 16'(k + 1));
      send(16'd1, "t1_imp");
      check("t1_y0_const", m_data, 64'd1);
      for (int i = 0; i < 8; i++) send(16'd0, "t1_tail");
      check("t1_y8_const", m_data, 64'd0);

      // Rounding: 3*0.5 -> 2, -3*0.5 -> -1.
      select(0);
      wcoef(0, 16'h4000);
      send(16'd3, "t3_pos");
      check("t3_pos_const", m_data, 64'h2);
      send(16'hFFFD, "t3_neg");
      check("t3_neg_const", m_data, 64'hFFFF);

      for (int k = 0; k < 64; k++) wcoef(k, 16'($urandom));
      for (int i = 0; i < 20; i++) begin
         accept(16'($urandom));
         wait_out("rnd", 1'b1);
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
            check("rnd_hold_valid", 64'(m_valid), 64'd1);
         end
         pop();
      end

      for (int k = 0; k < 64; k++) wcoef(k, 16'h7FFF);
      for (int i = 0; i < 64; i++) send(16'h7FFF, "t2_pos");
      check("t2_pos_const_y", m_data, 64'h7FFF);
      check("t2_pos_const_sat", 64'(m_sat), 64'd1);
      for (int i = 0; i < 64; i++) send(16'h8000, "t2_neg");
      check("t2_neg_const_y", m_data, 64'h8000);
      check("t2_neg_const_sat", 64'(m_sat), 64'd1);

      // Backpressure with a second sample already offered.
      accept(16'h1234);
      wait_out("t4", 1'b1);
      in_valid = 1'b1;
      in_data  = 16'h0777;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("t4_hold_valid", 64'(m_valid), 64'd1);
         check("t4_hold_y", m_data, exp_y);
         check("t4_hold_shift", m_shift, exp_shift);
         check("t4_hold_ready", 64'(m_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("t4_idle_after_hs", 64'(m_ready), 64'd1);
      check("t4_valid_drop", 64'(m_valid), 64'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      model_push(16'h0777);
      check("t4_second_taken", 64'(m_ready), 64'd0);
      wait_out("t4b", 1'b1);
      pop();

      // Illegal write during MAC, then flush.
      select(1);
      accept(16'h0003);
      coeff_we    = 1'b1;
      coeff_addr  = 6'd0;
      coeff_wdata = 16'd99;
      @(posedge clk); #1;
      coeff_we = 1'b0;
      check("t5_err_set", 64'(m_err), 64'd1);
      wait_out("t5_ignored", 1'b0);
      pop();
      check("t5_err_sticky", 64'(m_err), 64'd1);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = 16'h0009;
      @(posedge clk); #1;
      clear    = 1'b0;
      in_valid = 1'b0;
      flush_model();
      check("t5_err_cleared", 64'(m_err), 64'd0);
      check("t5_clear_idle", 64'(m_ready), 64'd1);
      @(posedge clk); #1;
      check("t5_clear_no_accept", 64'(m_ready), 64'd1);
      wcoef(0, 16'd2);
      send(16'd5, "t5_flush");
      check("t5_flush_const", m_data, 64'd10);

      accept(16'h0011);
      @(posedge clk); #1;
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      flush_model();
      check("t5_abort_idle", 64'(m_ready), 64'd1);
      seen = 0;
      repeat (10) begin
         @(posedge clk); #1;
         seen = seen | int'(m_valid);
      end
      check("t5_abort_no_out", 64'(seen), 64'd0);
      send(16'h0002, "t5_after_abort");

      // Asynchronous reset in the middle of a MAC pass.
      select(0);
      accept(16'h0100);
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", 64'(m_valid), 64'd0);
      check("t6_rst_ready", 64'(m_ready), 64'd1);
      check("t6_rst_data", m_data, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      reset_model();
      @(posedge clk); #1;
      send(16'h0123, "t6_post");
      check("t6_post_const", m_data, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
